riscv_v_slide_unit: RTL and testbench



---
 rtl/riscv_v_slide_unit.sv | 161 ++++++++++++++++
 tb/tb_riscv_v_slide_unit.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/riscv_v_slide_unit.sv
// Element-granular slide engine for vslideup / vslidedown on one vector
// register. The byte offset is resolved by an iterative barrel shifter,
// one log2 stage per cycle, so every request has the same fixed latency.
//
// Handshake: a transfer happens on an edge where valid and ready are both
// high. The producer keeps valid and its payload steady until that edge.
// in_ready is high only in IDLE and out_valid is high only in DONE, so the
// unit holds at most one request at a time. result stays steady while
// out_valid is high.
module riscv_v_slide_unit #(
  parameter int DATA_WIDTH   = 128,
  parameter int OFFSET_WIDTH = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic                    is_down,
  input  logic [3:0]              osize_vector,
  input  logic [OFFSET_WIDTH-1:0] offset,
  input  logic [DATA_WIDTH-1:0]   vs2,
  input  logic [DATA_WIDTH-1:0]   vd_old,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [DATA_WIDTH-1:0]   result
);

  localparam int NUM_BYTES = DATA_WIDTH / 8;
  localparam int STAGES    = $clog2(NUM_BYTES);
  localparam int BOFF_W    = STAGES + 1;
  localparam int CNT_W     = (STAGES > 1) ? $clog2(STAGES) : 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [DATA_WIDTH-1:0] sh_q, sh_d;
  logic [NUM_BYTES-1:0]  keep_q, keep_d;
  logic [DATA_WIDTH-1:0] vd_old_q;
  logic                  is_down_q;
  logic [BOFF_W-1:0]     boff_q;
  logic [CNT_W-1:0]      cnt_q;

  logic                  accept;
  logic                  last_stage;
  logic                  sat_q;
  logic [1:0]            esz_log2;
  logic [OFFSET_WIDTH:0] vlmax;
  logic                  sat_c;
  logic [BOFF_W-1:0]     boff_c;
  logic [DATA_WIDTH-1:0] merged;

  assign accept     = in_valid && in_ready;
  assign last_stage = (cnt_q == CNT_W'(STAGES - 1));
  // Only a saturated offset reaches the top boff bit (boff == NUM_BYTES).
  assign sat_q      = boff_q[BOFF_W-1];

  // Element size decode and byte offset; a non-one-hot size falls back to bytes.
  always_comb begin
    esz_log2 = 2'd0;
    case (osize_vector)
      4'b0001: esz_log2 = 2'd0;
      4'b0010: esz_log2 = 2'd1;
      4'b0100: esz_log2 = 2'd2;
      4'b1000: esz_log2 = 2'd3;
      default: esz_log2 = 2'd0;
    endcase
    vlmax  = (OFFSET_WIDTH + 1)'(NUM_BYTES) >> esz_log2;
    sat_c  = ({1'b0, offset} >= vlmax);
    // When not saturated offset < VLMAX, so the low bits hold it exactly.
    boff_c = sat_c ? BOFF_W'(NUM_BYTES)
                   : (BOFF_W'(offset[BOFF_W-1:0]) << esz_log2);
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (in_valid)  state_d = S_SHIFT;
      S_SHIFT: if (last_stage) state_d = S_DONE;
      S_DONE:  if (out_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // FSM outputs.
  always_comb begin
    in_ready  = (state_q == S_IDLE);
    out_valid = (state_q == S_DONE);
  end

  // One barrel stage: shift data and keep-mask by 2^cnt bytes when that boff bit is set.
  always_comb begin
    int unsigned sh_bytes;
    sh_bytes = 32'd1 << cnt_q;
    sh_d     = sh_q;
    keep_d   = keep_q;
    if (sat_q) begin
      sh_d   = '0;
      keep_d = '0;
    end else if (boff_q[cnt_q]) begin
      if (is_down_q) begin
        sh_d   = sh_q >> (sh_bytes * 8);
        keep_d = keep_q >> sh_bytes;
      end else begin
        sh_d   = sh_q << (sh_bytes * 8);
        keep_d = keep_q << sh_bytes;
      end
    end
  end

  // Merge the final stage output with vd_old (up) or zero (down) per byte.
  always_comb begin
    merged = '0;
    for (int b = 0; b < NUM_BYTES; b++) begin
      if (keep_d[b])       merged[b*8 +: 8] = sh_d[b*8 +: 8];
      else if (!is_down_q) merged[b*8 +: 8] = vd_old_q[b*8 +: 8];
      else                 merged[b*8 +: 8] = 8'h00;
    end
  end

  // Datapath: capture on acceptance, step the shifter in SHIFT, register the merge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sh_q      <= '0;
      keep_q    <= '0;
      vd_old_q  <= '0;
      is_down_q <= 1'b0;
      boff_q    <= '0;
      cnt_q     <= '0;
      result    <= '0;
    end else if (accept) begin
      sh_q      <= vs2;
      keep_q    <= '1;
      vd_old_q  <= vd_old;
      is_down_q <= is_down;
      boff_q    <= boff_c;
      cnt_q     <= '0;
    end else if (state_q == S_SHIFT) begin
      sh_q   <= sh_d;
      keep_q <= keep_d;
      if (last_stage) begin
        cnt_q  <= '0;
        result <= merged;
      end else begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_riscv_v_slide_unit.sv
// Bench for riscv_v_slide_unit: directed cases with hand-computed results,
// randomized cases against a byte-level reference model, backpressure,
// back-to-back and mid-operation reset.
module tb_riscv_v_slide_unit;

  localparam int DW  = 128;
  localparam int OW  = 16;
  localparam int NB  = DW / 8;
  localparam int LAT = 5;

  logic          clk;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic          is_down;
  logic [3:0]    osize_vector;
  logic [OW-1:0] offset;
  logic [DW-1:0] vs2;
  logic [DW-1:0] vd_old;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] result;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  bit seen   = 0;

  logic [DW-1:0] exp_q[$];
  int            lat_q[$];

  riscv_v_slide_unit #(.DATA_WIDTH(DW), .OFFSET_WIDTH(OW)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .is_down      (is_down),
    .osize_vector (osize_vector),
    .offset       (offset),
    .vs2          (vs2),
    .vd_old       (vd_old),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .result       (result)
  );

  // Clock and cycle counter.
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, need finish before 200000ns");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Reference: element slide expressed byte by byte from first principles.
  function automatic logic [DW-1:0] model(input bit d, input logic [3:0] osz,
                                          input logic [OW-1:0] off,
                                          input logic [DW-1:0] v2, input logic [DW-1:0] vo);
    logic [DW-1:0] r;
    int esz, vl, boff, src;
    case (osz)
      4'b0001: esz = 1;
      4'b0010: esz = 2;
      4'b0100: esz = 4;
      4'b1000: esz = 8;
      default: esz = 1;
    endcase
    vl   = NB / esz;
    boff = (int'(off) >= vl) ? NB : int'(off) * esz;
    r    = '0;
    for (int i = 0; i < NB; i++) begin
      if (d) begin
        src = i + boff;
        r[i*8 +: 8] = (src < NB) ? v2[src*8 +: 8] : 8'h00;
      end else begin
        r[i*8 +: 8] = (i < boff) ? vo[i*8 +: 8] : v2[(i-boff)*8 +: 8];
      end
    end
    return r;
  endfunction

  // Driver: present a request until accepted, push its expectation, then scramble inputs.
  task automatic send(input bit d, input logic [3:0] osz, input logic [OW-1:0] off,
                      input logic [DW-1:0] v2, input logic [DW-1:0] vo,
                      input logic [DW-1:0] exp, output int acc);
    int n = 0;
    in_valid     = 1'b1;
    is_down      = d;
    osize_vector = osz;
    offset       = off;
    vs2          = v2;
    vd_old       = vo;
    while (!in_ready && n < 100) begin
      tick();
      n++;
    end
    check("accept_ready", {127'b0, in_ready}, 1);
    acc = cyc;
    if (in_ready) begin
      exp_q.push_back(exp);
      lat_q.push_back(cyc);
      tick();
    end
    in_valid     = 1'b0;
    is_down      = 1'($urandom_range(0, 1));
    osize_vector = 4'($urandom);
    offset       = 16'($urandom);
    vs2          = {$urandom, $urandom, $urandom, $urandom};
    vd_old       = {$urandom, $urandom, $urandom, $urandom};
  endtask

  task automatic wait_drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      tick();
      n++;
    end
    check("drain", exp_q.size(), 0);
  endtask

  // Scoreboard monitor: latency on first sight of out_valid, result on handshake.
  always @(negedge clk) begin
    if (!rst_n) begin
      seen = 0;
    end else if (out_valid) begin
      if (!seen) begin
        seen = 1;
        check("latency_pending", {127'b0, lat_q.size() > 0}, 1);
        if (lat_q.size() > 0) check("latency", cyc - lat_q.pop_front(), LAT);
      end
      if (out_ready) begin
        check("result_pending", {127'b0, exp_q.size() > 0}, 1);
        if (exp_q.size() > 0) check("result", result, exp_q.pop_front());
        seen = 0;
      end
    end
  end

  initial begin
    int acc1, acc2, n;
    logic [DW-1:0] held, v2, vo;
    logic [3:0] osz;
    logic [OW-1:0] off;
    bit d;

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    is_down = 1'b0; osize_vector = 4'b0001; offset = '0; vs2 = '0; vd_old = '0;
    repeat (3) tick();
    check("rst_in_ready", {127'b0, in_ready}, 1);
    check("rst_out_valid", {127'b0, out_valid}, 0);
    check("rst_result", result, '0);
    rst_n = 1'b1;
    tick();

    // Directed cases.
    send(1, 4'b0001, 16'd3, 128'h0F0E0D0C0B0A09080706050403020100, '0,
         128'h0000000F0E0D0C0B0A09080706050403, acc1);
    wait_drain();
    send(0, 4'b0100, 16'd1, 128'hDDDDDDDD_CCCCCCCC_BBBBBBBB_AAAAAAAA, {16{8'h11}},
         128'hCCCCCCCC_BBBBBBBB_AAAAAAAA_11111111, acc1);
    wait_drain();
    send(1, 4'b1000, 16'd2, 128'h0123456789ABCDEF_FEDCBA9876543210, {16{8'h55}},
         '0, acc1);
    wait_drain();
    send(0, 4'b1000, 16'hFFFF, 128'h0123456789ABCDEF_FEDCBA9876543210, 128'h33221100_77665544_BBAA9988_FFEEDDCC,
         128'h33221100_77665544_BBAA9988_FFEEDDCC, acc1);
    wait_drain();
    send(1, 4'b0010, 16'd0, 128'hA5A5_1234_5678_9ABC_DEF0_0F1E_2D3C_4B5A, {16{8'hEE}},
         128'hA5A5_1234_5678_9ABC_DEF0_0F1E_2D3C_4B5A, acc1);
    wait_drain();

    // Backpressure on an offset-0 slide-up.
    out_ready = 1'b0;
    send(0, 4'b0010, 16'd0, 128'h1111_2222_3333_4444_5555_6666_7777_8888, {16{8'hEE}},
         128'h1111_2222_3333_4444_5555_6666_7777_8888, acc1);
    n = 0;
    while (!out_valid && n < 50) begin
      tick();
      n++;
    end
    check("bp_valid_seen", {127'b0, out_valid}, 1);
    held = 128'h1111_2222_3333_4444_5555_6666_7777_8888;
    for (int i = 0; i < 10; i++) begin
      check("bp_out_valid", {127'b0, out_valid}, 1);
      check("bp_result", result, held);
      check("bp_in_ready", {127'b0, in_ready}, 0);
      in_valid = 1'(i % 2);
      vs2      = {$urandom, $urandom, $urandom, $urandom};
      tick();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    check("release_in_ready", {127'b0, in_ready}, 1);
    check("release_out_valid", {127'b0, out_valid}, 0);
    check("release_queue", exp_q.size(), 0);

    // Back-to-back with in_valid effectively held high.
    v2 = 128'h00112233_44556677_8899AABB_CCDDEEFF;
    send(1, 4'b0001, 16'd15, v2, '0, 128'h00000000_00000000_00000000_00000000 | 128'h00, acc1);
    send(0, 4'b0001, 16'd15, v2, {16{8'h77}}, 128'hFF777777_77777777_77777777_77777777, acc2);
    check("b2b_spacing", acc2 - acc1, LAT + 1);
    wait_drain();

    // Randomized against the reference model.
    for (int i = 0; i < 24; i++) begin
      d = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 4))
        0: osz = 4'b0001;
        1: osz = 4'b0010;
        2: osz = 4'b0100;
        3: osz = 4'b1000;
        default: osz = 4'($urandom);
      endcase
      off = ($urandom_range(0, 3) == 0) ? 16'($urandom) : 16'($urandom_range(0, 17));
      v2  = {$urandom, $urandom, $urandom, $urandom};
      vo  = {$urandom, $urandom, $urandom, $urandom};
      send(d, osz, off, v2, vo, model(d, osz, off, v2, vo), acc1);
    end
    wait_drain();

    // Reset while the shifter is at stage 2.
    send(1, 4'b0001, 16'd5, {$urandom, $urandom, $urandom, $urandom}, '0, '0, acc1);
    tick();
    tick();
    exp_q.delete();
    lat_q.delete();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("midrst_in_ready", {127'b0, in_ready}, 1);
    check("midrst_out_valid", {127'b0, out_valid}, 0);
    check("midrst_result", result, '0);
    repeat (8) tick();
    check("midrst_no_pulse", {127'b0, out_valid}, 0);
    v2 = 128'h0F0E0D0C0B0A09080706050403020100;
    send(0, 4'b0001, 16'd2, v2, {16{8'h99}}, 128'h0D0C0B0A09080706050403020100_9999, acc1);
    wait_drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
